snitch_icache_flush_ctrl: RTL and testbench

Sequences a full instruction-cache flush on behalf of NR_FETCH_PORTS cores.
- Collects per-core flush requests.
- Stalls new L1 lookups and drains in-flight refills.
- Sweeps every L1 line index through the tag-invalidate port.
- Pulses a flush to all L0 caches, then acknowledges the requesting cores.
- Sits beside the L1 lookup/handler stage and takes its dimensions from the shared config.

---
 rtl/snitch_icache_pkg.sv | 25 ++
 rtl/snitch_icache_flush_ctrl.sv | 108 ++++++++++
 tb/tb_snitch_icache_flush_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_icache_pkg.sv
// rtl/snitch_icache_pkg.sv - shared instruction-cache configuration and flush types
package snitch_icache_pkg;

   typedef struct packed {
      int unsigned nr_fetch_ports;
      int unsigned line_count;
   } config_t;

   localparam config_t DEFAULT_CFG = '{nr_fetch_ports: 2, line_count: 128};

   typedef enum logic [2:0] {
      FLUSH_IDLE,
      FLUSH_DRAIN,
      FLUSH_INVAL,
      FLUSH_L0,
      FLUSH_ACK
   } flush_state_e;

   typedef struct packed {
      logic flush_start;
      logic flush_done;
      logic flush_drain_stall;
   } icache_flush_events_t;

endpackage

// File: rtl/snitch_icache_flush_ctrl.sv
// rtl/snitch_icache_flush_ctrl.sv - full L1/L0 instruction-cache flush sequencer
// Every output is a flop updated together with the state, so nothing combinational reaches a port.
module snitch_icache_flush_ctrl
   import snitch_icache_pkg::*;
#(
   parameter int unsigned NR_FETCH_PORTS = DEFAULT_CFG.nr_fetch_ports,
   parameter int unsigned LINE_COUNT     = DEFAULT_CFG.line_count
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NR_FETCH_PORTS-1:0]       flush_valid_i,
   output logic [NR_FETCH_PORTS-1:0]       flush_ready_o,
   input  logic                            pending_i,
   output logic                            lookup_stall_o,
   output logic                            inval_valid_o,
   input  logic                            inval_ready_i,
   output logic [$clog2(LINE_COUNT)-1:0]   inval_line_o,
   output logic                            l0_flush_o,
   output logic                            busy_o
);

   localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
   localparam logic [COUNT_ALIGN-1:0] LAST_LINE = COUNT_ALIGN'(LINE_COUNT - 1);

   flush_state_e                state_q;
   logic [NR_FETCH_PORTS-1:0]   mask_q;
   logic [COUNT_ALIGN-1:0]      cnt_q;
   logic [NR_FETCH_PORTS-1:0]   ready_q;
   logic                        stall_q;
   logic                        inval_valid_q;
   logic                        l0_flush_q;
   logic                        busy_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= FLUSH_IDLE;
         mask_q        <= '0;
         cnt_q         <= '0;
         ready_q       <= '0;
         stall_q       <= 1'b0;
         inval_valid_q <= 1'b0;
         l0_flush_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         unique case (state_q)
            FLUSH_IDLE: begin
               if (|flush_valid_i) begin
                  mask_q  <= flush_valid_i;
                  stall_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= FLUSH_DRAIN;
               end
            end
            FLUSH_DRAIN: begin
               // Late requesters join this pass until the sweep starts.
               mask_q <= mask_q | flush_valid_i;
               if (!pending_i) begin
                  cnt_q         <= '0;
                  inval_valid_q <= 1'b1;
                  state_q       <= FLUSH_INVAL;
               end
            end
            FLUSH_INVAL: begin
               if (inval_ready_i) begin
                  if (cnt_q == LAST_LINE) begin
                     cnt_q         <= '0;
                     inval_valid_q <= 1'b0;
                     l0_flush_q    <= 1'b1;
                     state_q       <= FLUSH_L0;
                  end else begin
                     cnt_q <= cnt_q + COUNT_ALIGN'(1);
                  end
               end
            end
            FLUSH_L0: begin
               l0_flush_q <= 1'b0;
               stall_q    <= 1'b0;
               ready_q    <= mask_q;
               state_q    <= FLUSH_ACK;
            end
            FLUSH_ACK: begin
               ready_q <= '0;
               mask_q  <= '0;
               busy_q  <= 1'b0;
               state_q <= FLUSH_IDLE;
            end
            default: begin
               state_q       <= FLUSH_IDLE;
               mask_q        <= '0;
               cnt_q         <= '0;
               ready_q       <= '0;
               stall_q       <= 1'b0;
               inval_valid_q <= 1'b0;
               l0_flush_q    <= 1'b0;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign flush_ready_o  = ready_q;
   assign lookup_stall_o = stall_q;
   assign inval_valid_o  = inval_valid_q;
   assign inval_line_o   = cnt_q;
   assign l0_flush_o     = l0_flush_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_snitch_icache_flush_ctrl.sv
// tb/tb_snitch_icache_flush_ctrl.sv - scoreboard bench for the icache flush sequencer
module tb_snitch_icache_flush_ctrl;

   localparam int NP = 2;
   localparam int LC = 8;
   localparam int K_INV = 0;
   localparam int K_L0  = 1;
   localparam int K_ACK = 2;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NP-1:0] flush_valid = '0;
   logic [NP-1:0] flush_ready;
   logic          pending = 1'b0;
   logic          lookup_stall;
   logic          inval_valid;
   logic          inval_ready = 1'b1;
   logic [2:0]    inval_line;
   logic          l0_flush;
   logic          busy;

   int            cyc = 0;
   int            checks = 0;
   int            failures = 0;
   exp_t          sb[$];
   bit            directed = 1'b1;
   int            inv_cnt = 0;
   bit            prev_hold = 1'b0;
   int            prev_line = 0;
   logic [NP-1:0] outstanding = '0;
   int            n_raised = 0;
   int            n_acked = 0;

   snitch_icache_flush_ctrl #(.NR_FETCH_PORTS(NP), .LINE_COUNT(LC)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_valid_i  (flush_valid),
      .flush_ready_o  (flush_ready),
      .pending_i      (pending),
      .lookup_stall_o (lookup_stall),
      .inval_valid_o  (inval_valid),
      .inval_ready_i  (inval_ready),
      .inval_line_o   (inval_line),
      .l0_flush_o     (l0_flush),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int val, input int c);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   // t0 is the first INVAL cycle; lines from sline onward slip by slen cycles.
   task automatic push_pass(input int t0, input int mask, input int sline, input int slen);
      for (int i = 0; i < LC; i++)
         push(K_INV, i, t0 + i + ((i >= sline) ? slen : 0));
      push(K_L0, 0, t0 + LC + slen);
      push(K_ACK, mask, t0 + LC + 1 + slen);
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (sb.size() == 0 && !busy) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d events left busy=%0d, required 0 and idle", name, sb.size(), busy);
      sb.delete();
   endtask

   task automatic sb_event(input int kind, input int val);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_unexpected: got kind=%0d val=%0d at cycle %0d, required no event", kind, val, cyc);
      end else begin
         e = sb.pop_front();
         chk("sb_kind", kind, e.kind);
         chk("sb_value", val, e.val);
         chk("sb_cycle", cyc, e.cyc);
      end
   endtask

   // Core model: drop valid in the cycle after the ack was seen.
   always begin
      logic [NP-1:0] a;
      @(negedge clk);
      a = flush_ready;
      @(posedge clk);
      #1;
      flush_valid = flush_valid & ~a;
   end

   always @(negedge clk) begin
      if (rst) begin
         inv_cnt   = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("inval_hold_valid", int'(inval_valid), 1);
            chk("inval_hold_line", int'(inval_line), prev_line);
         end
         prev_hold = inval_valid && !inval_ready;
         prev_line = int'(inval_line);
         if (inval_valid) chk("stall_during_inval", int'(lookup_stall), 1);
         if (inval_valid && inval_ready) begin
            if (directed) sb_event(K_INV, int'(inval_line));
            else chk("rand_line_order", int'(inval_line), inv_cnt);
            inv_cnt++;
         end
         if (l0_flush) begin
            if (directed) sb_event(K_L0, 0);
            else chk("rand_lines_per_pass", inv_cnt, LC);
            inv_cnt = 0;
         end
         if (flush_ready != '0) begin
            if (directed) sb_event(K_ACK, int'(flush_ready));
            else begin
               chk("rand_ack_unrequested", int'(flush_ready & ~outstanding), 0);
               for (int c = 0; c < NP; c++) if (flush_ready[c]) n_acked++;
               outstanding = outstanding & ~flush_ready;
            end
         end
      end
   end

   initial begin
      int t;
      #3;
      chk("rst_ready", int'(flush_ready), 0);
      chk("rst_stall", int'(lookup_stall), 0);
      chk("rst_inval_valid", int'(inval_valid), 0);
      chk("rst_inval_line", int'(inval_line), 0);
      chk("rst_l0", int'(l0_flush), 0);
      chk("rst_busy", int'(busy), 0);
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("idle_busy", int'(busy), 0);

      // Best-case single request
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      push_pass(t + 2, 1, LC, 0);
      wait_done("t1", 40);

      // Refills still in flight for five cycles
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      pending = 1'b1;
      push_pass(t + 7, 1, LC, 0);
      step();
      chk("t2_stall_in_drain", int'(lookup_stall), 1);
      chk("t2_no_inval_in_drain", int'(inval_valid), 0);
      repeat (5) step();
      pending = 1'b0;
      wait_done("t2", 40);

      // Tag array back-pressure at line 3
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      push_pass(t + 2, 1, 3, 3);
      repeat (5) step();
      inval_ready = 1'b0;
      repeat (3) step();
      inval_ready = 1'b1;
      wait_done("t3", 40);

      // Core1 joins during DRAIN: one shared ack
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      push_pass(t + 2, 3, LC, 0);
      step();
      flush_valid[1] = 1'b1;
      wait_done("t4a", 40);

      // Core1 joins during INVAL: served by a second pass
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      push_pass(t + 2, 1, LC, 0);
      push_pass(t + 14, 2, LC, 0);
      repeat (2) step();
      flush_valid[1] = 1'b1;
      wait_done("t4b", 80);

      // Reset in the middle of the sweep
      step();
      t = cyc;
      flush_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) push(K_INV, i, t + 2 + i);
      repeat (7) step();
      chk("t5_line_before_rst", int'(inval_line), 5);
      rst = 1'b1;
      flush_valid = '0;
      #1;
      chk("t5_rst_ready", int'(flush_ready), 0);
      chk("t5_rst_stall", int'(lookup_stall), 0);
      chk("t5_rst_inval_valid", int'(inval_valid), 0);
      chk("t5_rst_inval_line", int'(inval_line), 0);
      chk("t5_rst_l0", int'(l0_flush), 0);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_events_seen", sb.size(), 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (20) step();
      chk("t5_idle_after_rst", int'(busy), 0);

      // Random traffic
      directed = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         step();
         for (int c = 0; c < NP; c++) begin
            if (!flush_valid[c] && !flush_ready[c] && $urandom_range(0, 15) == 0) begin
               flush_valid[c] = 1'b1;
               outstanding[c] = 1'b1;
               n_raised++;
            end
         end
         pending     = ($urandom_range(0, 3) == 0);
         inval_ready = ($urandom_range(0, 3) != 0);
      end
      pending     = 1'b0;
      inval_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         step();
         if (outstanding == '0 && !busy && flush_valid == '0) break;
      end
      chk("rand_outstanding", int'(outstanding), 0);
      chk("rand_acked_once", n_acked, n_raised);
      chk("rand_final_idle", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
